// File: rtl/gbf_in_fetcher_pkg.sv
// Shared constants, FSM state type and the wrapping address helper for the
// GBF_in read-side fetcher.
package gbf_pkg;

    localparam int WIDTH  = 32;
    localparam int HEIGHT = 48;
    localparam int AW     = $clog2(HEIGHT);
    localparam int NLANE  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // (a + inc) mod HEIGHT by a single compare-and-subtract.
    // The result is only correct for a < HEIGHT and inc <= HEIGHT.
    function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] a,
                                               input logic [AW:0]   inc);
        logic [AW:0] sum;
        sum = {1'b0, a} + inc;
        if (sum >= (AW+1)'(HEIGHT))
            sum = sum - (AW+1)'(HEIGHT);
        return sum[AW-1:0];
    endfunction

endpackage

// File: rtl/gbf_in_fetcher_out_reg.sv
// Valid/ready output register for fetched groups. It holds its data while
// stalled and drops valid on a handshake when no new group is loaded.
module gbf_out_reg
    import gbf_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [NLANE*WIDTH-1:0] data,
    input  logic                   last,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [NLANE*WIDTH-1:0] out_data,
    output logic                   out_last
);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= data;
            out_last  <= last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/gbf_in_fetcher.sv
// Sequences bursts of 4-word groups out of the quad-port GBF_in and streams
// them downstream over a valid/ready handshake.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; all read addresses are 0
//   ST_FETCH | drives cur..cur+3 and loads a group whenever the reg is free
//   ST_DRAIN | last group loaded; waiting for its handshake
module gbf_in_fetcher
    import gbf_pkg::*;
#(
    parameter int GW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [AW-1:0]          base_addr,
    input  logic [GW-1:0]          num_groups,
    output logic [AW-1:0]          addr_a,
    output logic [AW-1:0]          addr_b,
    output logic [AW-1:0]          addr_c,
    output logic [AW-1:0]          addr_d,
    input  logic [WIDTH-1:0]       q_a,
    input  logic [WIDTH-1:0]       q_b,
    input  logic [WIDTH-1:0]       q_c,
    input  logic [WIDTH-1:0]       q_d,
    output logic [NLANE*WIDTH-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    state_t        state, state_nxt;
    logic [AW-1:0] cur;
    logic [GW-1:0] rem;
    logic          load, accept, zero_req, bad_req, last_hs;
    logic [AW-1:0] lane_addr [NLANE];

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        accept    = 1'b0;
        zero_req  = 1'b0;
        bad_req   = 1'b0;
        last_hs   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if ({1'b0, base_addr} >= (AW+1)'(HEIGHT)) begin
                        bad_req = 1'b1;
                    end else if (num_groups == '0) begin
                        zero_req = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                load = !out_valid || out_ready;
                if (load && rem == GW'(1))
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_valid && out_ready) begin
                    last_hs   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cur   <= '0;
            rem   <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= zero_req || last_hs;
            err   <= bad_req;
            if (accept) begin
                cur <= base_addr;
                rem <= num_groups;
            end else if (load) begin
                cur <= wrap_add(cur, (AW+1)'(NLANE));
                rem <= rem - GW'(1);
            end
        end
    end

    // Addresses come straight from cur, so a stalled fetch keeps them frozen.
    always_comb begin
        for (int i = 0; i < NLANE; i++) begin
            lane_addr[i] = '0;
            if (state == ST_FETCH)
                lane_addr[i] = wrap_add(cur, (AW+1)'(i));
        end
    end

    assign addr_a = lane_addr[0];
    assign addr_b = lane_addr[1];
    assign addr_c = lane_addr[2];
    assign addr_d = lane_addr[3];
    assign busy   = (state != ST_IDLE);

    gbf_out_reg u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .data      ({q_d, q_c, q_b, q_a}),
        .last      (rem == GW'(1)),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last)
    );

endmodule

// File: tb/tb_gbf_in_fetcher.sv
// Directed bench for gbf_in_fetcher against a behavioural GBF_in model
// preloaded with mem[i] = i.
module tb_gbf_in_fetcher;
    import gbf_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic [AW-1:0]          base_addr = '0;
    logic [7:0]             num_groups = '0;
    logic [AW-1:0]          addr_a, addr_b, addr_c, addr_d;
    logic [WIDTH-1:0]       q_a, q_b, q_c, q_d;
    logic [NLANE*WIDTH-1:0] out_data;
    logic                   out_valid, out_last, busy, done, err;
    logic                   out_ready = 1'b1;

    logic [WIDTH-1:0] mem [64];
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [WIDTH-1:0] wr_data = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign q_a = mem[addr_a];
    assign q_b = mem[addr_b];
    assign q_c = mem[addr_c];
    assign q_d = mem[addr_d];

    always @(posedge clk)
        if (wr_en) mem[wr_addr] <= wr_data;

    gbf_in_fetcher dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_groups(num_groups),
        .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c), .addr_d(addr_d),
        .q_a(q_a), .q_b(q_b), .q_c(q_c), .q_d(q_d),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done), .err(err)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] grp(input int w0, input int w1, input int w2, input int w3);
        return {32'(w3), 32'(w2), 32'(w1), 32'(w0)};
    endfunction

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic kick(input int base, input int ng);
        base_addr  = AW'(base);
        num_groups = 8'(ng);
        start      = 1'b1;
        nxt();
        start      = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'(i);

        nxt(); nxt();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", {addr_a, addr_b, addr_c, addr_d}, 0);
        chk("rst_done_err", {done, err}, 0);
        rst = 1'b0;

        // basic burst, immediately after reset
        kick(0, 3);
        chk("b1_busy", busy, 1);
        chk("b1_novalid", out_valid, 0);
        chk("b1_addr", {addr_a, addr_b, addr_c, addr_d}, {6'd0, 6'd1, 6'd2, 6'd3});
        nxt();
        chk("b1_g0", out_data, grp(0, 1, 2, 3));
        chk("b1_v0", {out_valid, out_last}, 2'b10);
        chk("b1_addr1", addr_a, 4);
        nxt();
        chk("b1_g1", out_data, grp(4, 5, 6, 7));
        chk("b1_l1", out_last, 0);
        nxt();
        chk("b1_g2", out_data, grp(8, 9, 10, 11));
        chk("b1_l2", {out_valid, out_last, busy, done}, 4'b1110);
        chk("b1_drain_addr", addr_a, 0);
        nxt();
        chk("b1_done", {done, busy, out_valid}, 3'b100);
        nxt();
        chk("b1_done_pulse", done, 0);

        // wrap
        kick(46, 2);
        chk("w_addr", {addr_a, addr_b, addr_c, addr_d}, {6'd46, 6'd47, 6'd0, 6'd1});
        nxt();
        chk("w_g0", out_data, grp(46, 47, 0, 1));
        nxt();
        chk("w_g1", out_data, grp(2, 3, 4, 5));
        chk("w_last", out_last, 1);
        nxt();
        chk("w_done", done, 1);

        // backpressure: 3 stalled cycles after the first valid
        kick(8, 4);
        out_ready = 1'b0;
        nxt();
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold", out_data, grp(8, 9, 10, 11));
            chk("bp_vld", {out_valid, out_last}, 2'b10);
            chk("bp_addr", {addr_a, addr_d}, {6'd12, 6'd15});
            nxt();
        end
        out_ready = 1'b1;
        chk("bp_rel", out_data, grp(8, 9, 10, 11));
        nxt();
        chk("bp_g1", out_data, grp(12, 13, 14, 15));
        nxt();
        chk("bp_g2", out_data, grp(16, 17, 18, 19));
        nxt();
        chk("bp_g3", out_data, grp(20, 21, 22, 23));
        chk("bp_last", out_last, 1);
        nxt();
        chk("bp_done", {done, out_valid}, 2'b10);

        // degenerate starts
        kick(5, 0);
        chk("z_done", {done, busy, out_valid}, 3'b100);
        kick(48, 2);
        chk("e_err", {err, busy, done, out_valid}, 4'b1000);
        nxt();
        chk("e_err_pulse", {err, busy}, 2'b00);

        // start mid-burst is ignored
        kick(20, 3);
        base_addr = '0; num_groups = 8'd1; start = 1'b1;
        nxt();
        start = 1'b0;
        chk("ms_g0", out_data, grp(20, 21, 22, 23));
        chk("ms_err", err, 0);
        nxt();
        chk("ms_g1", out_data, grp(24, 25, 26, 27));
        nxt();
        chk("ms_g2", {out_data, out_last}, {grp(28, 29, 30, 31), 1'b1});
        nxt();
        chk("ms_done", {done, err, busy}, 3'b100);

        // reset mid-burst, then a fresh burst
        kick(0, 5);
        nxt();
        chk("rm_pre", out_valid, 1);
        rst = 1'b1;
        nxt();
        chk("rm_clear", {out_valid, out_last, busy, done, err}, 0);
        chk("rm_data", out_data, 0);
        chk("rm_addr", {addr_a, addr_b, addr_c, addr_d}, 0);
        rst = 1'b0;
        kick(40, 2);
        chk("rm_nodone", done, 0);
        nxt();
        chk("rm_g0", out_data, grp(40, 41, 42, 43));
        nxt();
        chk("rm_g1", out_data, grp(44, 45, 46, 47));
        nxt();
        chk("rm_done", done, 1);

        // write in the same cycle as the fetch of that address
        kick(4, 1);
        chk("col_addr_b", addr_b, 5);
        wr_en = 1'b1; wr_addr = 6'd5; wr_data = 32'hAAAA;
        nxt();
        wr_en = 1'b0;
        chk("col_old", out_data, grp(4, 5, 6, 7));
        nxt();
        chk("col_done", done, 1);
        kick(4, 1);
        nxt();
        chk("col_new", out_data, grp(4, 32'hAAAA, 6, 7));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gbf_in_fetcher.md
Name: gbf_in_fetcher

Overview:
Read-side sequencer for the quad-port input global buffer (GBF_in, 4 ports, asynchronous read, 32-bit words, 48 entries). On a start command it drives all four buffer read addresses each cycle and fetches a burst of 4-word groups from consecutive, wrapping addresses. Each group is registered and streamed to the downstream PE array over a valid/ready handshake with full backpressure. It never writes the buffer; the buffer's write enables belong to the upstream writer.

Parameters:
WIDTH, 32, word width; must match the buffer.
HEIGHT, 48, buffer depth in words; AW = $clog2(HEIGHT).
GW, 8, width of the group-count field.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle burst request; sampled only in IDLE.
base_addr  in  AW  first word address of the burst.
num_groups  in  GW  number of 4-word groups in the burst.
addr_a, addr_b, addr_c, addr_d  out  AW  buffer read addresses for ports a to d.
q_a, q_b, q_c, q_d  in  WIDTH  buffer read data (combinational from the addresses).
out_data  out  4*WIDTH  group data; [WIDTH-1:0] = lane a, then b, c; d in the top word.
out_valid  out  1  out_data holds a valid group.
out_ready  in  1  downstream accepts the group.
out_last  out  1  qualifies the final group of a burst.
busy  out  1  high whenever the FSM is not in IDLE.
done  out  1  one-cycle pulse when the burst completes.
err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset values: all outputs 0, including the addresses, out_data, busy, done and err. FSM returns to IDLE.
- Reset mid-burst aborts the burst with no done pulse. A start in the first cycle after reset is accepted.
- FSM states: IDLE, FETCH, DRAIN.
- IDLE handling of start:
  - base_addr >= HEIGHT: err = 1 next cycle; FSM stays in IDLE.
  - num_groups == 0: done = 1 next cycle; FSM stays in IDLE; no output.
  - Otherwise: latch cur = base_addr and rem = num_groups, then go to FETCH.
- start is ignored outside IDLE, with no err.
- Address generation:
  - In FETCH, lane i (a=0, b=1, c=2, d=3) is driven with (cur + i) mod HEIGHT.
  - In IDLE and DRAIN, all four addresses are 0.
  - Wrap uses compare-and-subtract only, no divider.
- Load condition in FETCH: load = !out_valid || out_ready.
- On load:
  - out_data <= {q_d, q_c, q_b, q_a}; out_valid <= 1.
  - out_last <= (rem == 1).
  - cur <= (cur + 4) mod HEIGHT; rem <= rem - 1.
  - If rem == 1, go to DRAIN.
- Without load, cur, rem and all addresses hold, so a stalled group is never skipped or duplicated.
- Output register:
  - out_data and out_last are stable while out_valid && !out_ready.
  - out_valid clears on a handshake with no new load.
- DRAIN: the handshake on the last group returns the FSM to IDLE and raises done the next cycle. busy falls in that same cycle.
- Latency and throughput:
  - start accepted at edge 0 gives FETCH at edge 1 and out_valid at edge 2.
  - Sustained rate is 1 group per cycle when out_ready = 1.
- A back-to-back start is accepted in the cycle done is high.
- Write/read collision: if the writer writes an address in the same cycle it is fetched, the pre-write value is captured, because buffer writes land at the clock edge.
- Counter width: rem is GW bits. cur + 4 is computed at AW+1 bits before the wrap.

Decomposition:
- Package gbf_pkg holds:
  - WIDTH, HEIGHT and AW;
  - the lane-count constant NLANE = 4;
  - the FSM state enum.
- One sub-module, gbf_out_reg: the valid/ready output register. It takes load, data and last in, and drives out_valid, out_data and out_last. The FSM and address generation stay in the top module.

Test Plan:
Bench buffer model: preload mem[i] = i, asynchronous read.
- base=0, num_groups=3, out_ready=1:
  - groups are {0,1,2,3}, {4,5,6,7}, {8,9,10,11};
  - first out_valid 2 cycles after start;
  - out_last only on the third group;
  - done pulses one cycle after the third handshake.
- Wrap, base=46, num_groups=2: groups are {46,47,0,1} then {2,3,4,5}, and addr_c = 0 during the first fetch.
- Backpressure, base=8, num_groups=4, out_ready low for 3 cycles after the first valid:
  - out_data holds {8,9,10,11} throughout the stall;
  - addresses stay frozen;
  - the output sequence has no gaps or repeats.
- Degenerate starts:
  - num_groups=0: done next cycle, out_valid never rises;
  - base_addr=48: err next cycle, busy stays 0.
- Control events:
  - start pulsed mid-burst is ignored, and the burst completes unchanged;
  - rst asserted mid-burst gives all outputs 0 the next cycle and no done;
  - a new start then runs correctly.
- Collision: the writer writes mem[5]=0xAAAA in the same cycle addr_b=5 is fetched. That group shows 5, and a later burst reads 0xAAAA.
